keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment driver. The display time-multiplexes anodes outward; this block time-multiplexes columns of a 4x4 matrix keypad (Pmod KYPD) and reads the rows back.
- It debounces one key at a time and emits a one-cycle key strobe with a hex code.
- It also maintains four BCD digit registers (thousands/hundreds/tens/ones) that feed the display driver directly.

Parameters:
- SCAN_DIV_BITS, 14, width of the free-running divider; a scan tick fires when the divider wraps to 0 (~6 kHz column rate at 100 MHz).
- DEBOUNCE_SCANS, 4, consecutive matching scan ticks required to accept a press or a release (range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- row  in  4  keypad row lines, active-low, externally pulled up
- col  out  4  keypad column drive, active-low one-hot
- key_code  out  4  hex code of the last accepted key
- key_valid  out  1  one-cycle strobe on key acceptance
- thousands  out  4  BCD digit 3
- hundreds  out  4  BCD digit 2
- tens  out  4  BCD digit 1
- ones  out  4  BCD digit 0

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All state resets asynchronously.
- Reset values: col=4'b1110, key_code=0, key_valid=0, all digits=0, divider=0, state=SCAN, debounce count=0, synchronizer flops=4'hF.
- Row synchronizer: row passes through a 2-flop synchronizer before use. rs denotes the synchronized value.
- Scan tick: asserted for one clk when the divider equals 0. The divider free-runs from reset. All FSM decisions happen only on tick cycles.
- Key map (col index 0..3, row index 0..3):
  - row0 = 1 2 3 A
  - row1 = 4 5 6 B
  - row2 = 7 8 9 C
  - row3 = 0 F E D
  - Col index i corresponds to col bit i low.
- "Single press": rs has exactly one bit low. rs=4'hF is "none". Any other pattern is "multi" and is treated as none.
- SCAN state, on tick:
  - Single press: latch row index, freeze col, count=1, go to DEBOUNCE.
  - Otherwise: rotate col left (1110 -> 1101 -> 1011 -> 0111 -> 1110).
- DEBOUNCE state, on tick:
  - Same single row still low: count+1.
  - When count reaches DEBOUNCE_SCANS, accept the key:
    - key_valid=1 for exactly one cycle (the cycle after that tick).
    - key_code updated on the same edge.
    - Go to HELD; count=0.
  - Released, multi, or a different row low: count=0, back to SCAN. col advances on that tick.
  - If DEBOUNCE_SCANS=1, the key is accepted at the tick after entry.
- HELD state (col stays frozen), on tick:
  - rs==4'hF: count+1.
  - Anything else: count=0.
  - When count reaches DEBOUNCE_SCANS: go to SCAN, count=0, col rotates. No strobe on release.
  - A held key never repeats.
- Digit update, on the same edge as key_valid:
  - Code 0..9: shift left, i.e. thousands<=hundreds, hundreds<=tens, tens<=ones, ones<=code. The old thousands digit is discarded.
  - Code C: all four digits cleared to 0.
  - Codes A, B, D, E, F: digits unchanged; key_valid and key_code still update.
- Invariants:
  - col is always one-hot active-low and changes only on tick cycles.
  - key_valid is never high on two consecutive cycles.
- Reset mid-operation (any state): all outputs return to reset values immediately. No strobe is emitted.

Decomposition:
- Shared package keypad_pkg holds:
  - FSM state encoding: SCAN, DEBOUNCE, HELD.
  - Key code constants: KEY_CLEAR=4'hC, and KEY_DIGIT_MAX=4'h9.
  - Default column pattern COL_FIRST=4'b1110.
- Sub-module keypad_decode: combinational; column index and row index (2 bits each) in, 4-bit hex code out, implementing the key map above. All sequential logic stays in keypad_scanner.

Test Plan (SCAN_DIV_BITS=4 so tick every 16 cycles, DEBOUNCE_SCANS=3):
- Reset, no keys -> col cycles 1110, 1101, 1011, 0111, 1110 with changes every 16 clks. key_valid stays 0; digits all 0.
- Press key "5" (row1 low while col=1101), held for 10 ticks -> exactly one key_valid pulse; key_code=5; ones=5. col frozen at 1101 until 3 release ticks, then advances to 1011.
- Enter 1, 2, 3, 4, 7 in sequence -> after the 4th key: thousands..ones = 1,2,3,4. After "7": 2,3,4,7.
- Bounce: key "9" low for 2 ticks, high for 1, low for 2 -> no key_valid. A subsequent stable 3 ticks -> one strobe; key_code=9.
- Two rows low simultaneously (rows 0 and 2 in col 0) -> treated as none; no strobe; col keeps rotating.
- Press "C" with digits 2,3,4,7 -> key_valid, key_code=C, all digits 0. Then assert rst mid-HELD -> col=1110, key_valid=0, digits 0 immediately.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam logic [3:0] KEY_CLEAR     = 4'hC;
    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] COL_FIRST     = 4'b1110;
    localparam logic [3:0] ROWS_NONE     = 4'hF;

    // True when exactly one of the active-low lines is pulled low.
    function automatic logic is_single(input logic [3:0] lines);
        logic [3:0] low;
        low = ~lines;
        return (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] lines);
        logic [1:0] idx;
        case (lines)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_decode.sv
// Combinational key map: column/row index pair to the printed hex legend.
module keypad_decode (
    input  logic [1:0] col_idx,
    input  logic [1:0] row_idx,
    output logic [3:0] code
);

    always_comb begin
        code = 4'h0;
        case ({row_idx, col_idx})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
    end

endmodule

// File: rtl/keypad_scanner.sv
// Column-multiplexed keypad scanner with per-key debounce and a 4-digit BCD entry register.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_BITS  = 14,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic [3:0] thousands,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    localparam logic [SCAN_DIV_BITS-1:0] DIV_ONE = SCAN_DIV_BITS'(1);
    localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_SCANS);

    logic [SCAN_DIV_BITS-1:0] div;
    logic                     tick;
    logic [3:0]               row_meta;
    logic [3:0]               rs;
    state_t                   state, state_n;
    logic [3:0]               count, count_n, count_inc;
    logic [3:0]               col_n, col_rot;
    logic [1:0]               row_idx, row_idx_n, rs_idx;
    logic                     single;
    logic                     accept;
    logic [3:0]               code;

    assign tick      = (div == '0);
    assign single    = is_single(rs);
    assign rs_idx    = low_index(rs);
    assign count_inc = count + 4'd1;
    assign col_rot   = {col[2:0], col[3]};

    keypad_decode u_decode (
        .col_idx (low_index(col)),
        .row_idx (row_idx),
        .code    (code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div      <= '0;
            row_meta <= ROWS_NONE;
            rs       <= ROWS_NONE;
        end else begin
            div      <= div + DIV_ONE;
            row_meta <= row;
            rs       <= row_meta;
        end
    end

    // Column stays frozen outside SCAN so the latched row keeps referring to the same key.
    always_comb begin
        state_n   = state;
        count_n   = count;
        col_n     = col;
        row_idx_n = row_idx;
        accept    = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (single) begin
                        row_idx_n = rs_idx;
                        count_n   = 4'd1;
                        state_n   = DEBOUNCE;
                    end else begin
                        col_n = col_rot;
                    end
                end
                DEBOUNCE: begin
                    if (single && (rs_idx == row_idx)) begin
                        if (count_inc >= DEB_TARGET) begin
                            accept  = 1'b1;
                            count_n = 4'd0;
                            state_n = HELD;
                        end else begin
                            count_n = count_inc;
                        end
                    end else begin
                        count_n = 4'd0;
                        state_n = SCAN;
                        col_n   = col_rot;
                    end
                end
                HELD: begin
                    if (rs == ROWS_NONE) begin
                        if (count_inc >= DEB_TARGET) begin
                            count_n = 4'd0;
                            state_n = SCAN;
                            col_n   = col_rot;
                        end else begin
                            count_n = count_inc;
                        end
                    end else begin
                        count_n = 4'd0;
                    end
                end
                default: begin
                    count_n = 4'd0;
                    state_n = SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SCAN;
            count   <= 4'd0;
            col     <= COL_FIRST;
            row_idx <= 2'd0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            col     <= col_n;
            row_idx <= row_idx_n;
        end
    end

    // key_valid is a one-cycle strobe with no back-pressure: key_code is valid
    // on the strobe cycle and holds until the next accepted key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            thousands <= 4'd0;
            hundreds  <= 4'd0;
            tens      <= 4'd0;
            ones      <= 4'd0;
        end else begin
            key_valid <= accept;
            if (accept) begin
                key_code <= code;
                if (code <= KEY_DIGIT_MAX) begin
                    thousands <= hundreds;
                    hundreds  <= tens;
                    tens      <= ones;
                    ones      <= code;
                end else if (code == KEY_CLEAR) begin
                    thousands <= 4'd0;
                    hundreds  <= 4'd0;
                    tens      <= 4'd0;
                    ones      <= 4'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix model.
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic [3:0] thousands, hundreds, tens, ones;

    logic       press_en;
    logic [1:0] press_row, press_col;
    logic       multi;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic prev_kv = 1'b0;

    keypad_scanner #(.SCAN_DIV_BITS(4), .DEBOUNCE_SCANS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .thousands (thousands),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A pressed key shorts its row to its column while that column is driven low.
    always_comb begin
        row = 4'hF;
        if (press_en && (col[press_col] == 1'b0)) row[press_row] = 1'b0;
        if (multi && (col[0] == 1'b0)) row = row & 4'b1010;
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert ($onehot(~col)) else begin
                errors++;
                $error("FAIL col_onehot observed=%b expected=one_low_bit", col);
            end
            if (key_valid) begin
                pulses++;
                checks++;
                assert (!prev_kv) else begin
                    errors++;
                    $error("FAIL strobe_single_cycle observed=%b expected=%b", prev_kv, 1'b0);
                end
            end
        end
        prev_kv = key_valid;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_digits(input string tag, input logic [15:0] exp);
        check(tag, {16'h0, thousands, hundreds, tens, ones}, {16'h0, exp});
    endtask

    task automatic wait_col(input string tag, input logic [3:0] target);
        int budget;
        budget = 0;
        while ((col !== target) && (budget < 100)) begin
            step(1);
            budget++;
        end
        check(tag, col, target);
    endtask

    task automatic wait_col_change(input string tag);
        logic [3:0] prev;
        int budget;
        prev = col;
        budget = 0;
        while ((col === prev) && (budget < 100)) begin
            step(1);
            budget++;
        end
        check(tag, (col !== prev), 1);
    endtask

    task automatic wait_strobe(input string tag);
        logic seen;
        int budget;
        seen = 1'b0;
        budget = 0;
        while (!seen && (budget < 300)) begin
            @(negedge clk);
            budget++;
            if (key_valid) seen = 1'b1;
        end
        check(tag, seen, 1);
    endtask

    task automatic press_and_release(input string tag, input logic [1:0] r, input logic [1:0] c,
                                     input logic [3:0] exp_code, input logic [15:0] exp_digits);
        press_row = r;
        press_col = c;
        press_en  = 1'b1;
        wait_strobe({tag, "_strobe"});
        check({tag, "_code"}, key_code, exp_code);
        check_digits({tag, "_digits"}, exp_digits);
        step(20);
        press_en = 1'b0;
        wait_col_change({tag, "_release"});
    endtask

    initial begin
        rst       = 1'b1;
        press_en  = 1'b0;
        press_row = 2'd0;
        press_col = 2'd0;
        multi     = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_col", col, 4'b1110);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check_digits("rst_digits", 16'h0000);

        // Idle scan: first tick lands on the first edge after release
        @(negedge clk);
        rst = 1'b0;
        step(1);
        check("scan_t0", col, 4'b1101);
        step(15);
        check("scan_between_ticks", col, 4'b1101);
        step(1);
        check("scan_t1", col, 4'b1011);
        step(16);
        check("scan_t2", col, 4'b0111);
        step(16);
        check("scan_t3", col, 4'b1110);
        check("scan_pulses", pulses, 0);
        check_digits("scan_digits", 16'h0000);

        // Key 5 held for 10 ticks, released for 3
        pulses    = 0;
        press_row = 2'd1;
        press_col = 2'd1;
        press_en  = 1'b1;
        step(64);
        check("k5_valid", key_valid, 1);
        check("k5_code", key_code, 4'h5);
        check_digits("k5_digits", 16'h0005);
        check("k5_col_frozen", col, 4'b1101);
        step(1);
        check("k5_valid_drop", key_valid, 0);
        step(111);
        check("k5_held_col", col, 4'b1101);
        press_en = 1'b0;
        step(32);
        check("k5_release2_col", col, 4'b1101);
        step(16);
        check("k5_release3_col", col, 4'b1011);
        check("k5_pulses", pulses, 1);

        // Bounce on key 9: two low ticks, one high, then low again
        wait_col("b9_align", 4'b1011);
        pulses    = 0;
        press_row = 2'd2;
        press_col = 2'd2;
        press_en  = 1'b1;
        step(32);
        press_en = 1'b0;
        step(16);
        check("b9_bounce_col", col, 4'b0111);
        check("b9_bounce_pulses", pulses, 0);
        press_en = 1'b1;
        step(32);
        check("b9_rescan_pulses", pulses, 0);
        press_and_release("k9", 2'd2, 2'd2, 4'h9, 16'h0059);
        check("b9_pulses", pulses, 1);

        // Digit entry sequence
        press_and_release("k1", 2'd0, 2'd0, 4'h1, 16'h0591);
        press_and_release("k2", 2'd0, 2'd1, 4'h2, 16'h5912);
        press_and_release("k3", 2'd0, 2'd2, 4'h3, 16'h9123);
        press_and_release("k4", 2'd1, 2'd0, 4'h4, 16'h1234);
        press_and_release("k7", 2'd2, 2'd0, 4'h7, 16'h2347);

        // Two rows low in column 0 count as no key
        pulses = 0;
        multi  = 1'b1;
        wait_col("multi_align", 4'b1110);
        step(16);
        check("multi_rotate", col, 4'b1101);
        step(64);
        check("multi_full_cycle", col, 4'b1101);
        check("multi_pulses", pulses, 0);
        check_digits("multi_digits", 16'h2347);
        multi = 1'b0;

        // Clear key, then reset while held
        pulses    = 0;
        press_row = 2'd2;
        press_col = 2'd3;
        press_en  = 1'b1;
        wait_strobe("kc_strobe");
        check("kc_code", key_code, 4'hC);
        check_digits("kc_digits", 16'h0000);
        step(40);
        check("kc_held_col", col, 4'b0111);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_col", col, 4'b1110);
        check("midrst_valid", key_valid, 0);
        check("midrst_code", key_code, 0);
        check_digits("midrst_digits", 16'h0000);
        press_en = 1'b0;
        step(3);
        @(negedge clk);
        rst = 1'b0;
        press_and_release("k8", 2'd2, 2'd1, 4'h8, 16'h0008);
        check("final_pulses", pulses, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
